memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_pkg.sv | 17 +
 rtl/memory_arbiter_if.sv | 47 ++++
 rtl/coord_to_address.sv | 20 ++
 rtl/memory_arbiter.sv | 166 ++++++++++++++++
 tb/tb_memory_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared constants and FSM state type for the video/MCU SRAM arbiter.
package memory_arbiter_pkg;

    localparam int unsigned SCREEN_WIDTH  = 320;
    localparam int unsigned SCREEN_HEIGHT = 240;
    localparam int unsigned SRAM_ADDR_W   = 17;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StReadDone,
        StWrite,
        StWriteDone,
        StSkipDone
    } state_e;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the scan-out read port, MCU write port and external SRAM pins.
interface memory_arbiter_if;
    import memory_arbiter_pkg::*;

    logic [8:0]             videoXCoord;
    logic [7:0]             videoYCoord;
    logic                   videoReadRequest;
    logic [7:0]             videoReadData;
    logic                   videoReadComplete;

    logic [8:0]             memoryXCoord;
    logic [7:0]             memoryYCoord;
    logic                   memoryWriteRequest;
    logic [7:0]             memoryWriteData;
    logic                   memoryWriteComplete;

    logic [SRAM_ADDR_W-1:0] sramAddress;
    logic [7:0]             sramDataOut;
    logic                   sramDataOutEnable;
    logic [7:0]             sramDataIn;
    logic                   sramChipEnableN;
    logic                   sramOutputEnableN;
    logic                   sramWriteEnableN;

    // Arbiter side.
    modport slave (
        input  videoXCoord, videoYCoord, videoReadRequest,
        output videoReadData, videoReadComplete,
        input  memoryXCoord, memoryYCoord, memoryWriteRequest, memoryWriteData,
        output memoryWriteComplete,
        output sramAddress, sramDataOut, sramDataOutEnable,
        input  sramDataIn,
        output sramChipEnableN, sramOutputEnableN, sramWriteEnableN
    );

    // Requester / SRAM model side.
    modport master (
        output videoXCoord, videoYCoord, videoReadRequest,
        input  videoReadData, videoReadComplete,
        output memoryXCoord, memoryYCoord, memoryWriteRequest, memoryWriteData,
        input  memoryWriteComplete,
        input  sramAddress, sramDataOut, sramDataOutEnable,
        output sramDataIn,
        input  sramChipEnableN, sramOutputEnableN, sramWriteEnableN
    );

endinterface

// File: rtl/coord_to_address.sv
// Combinational pixel coordinate to linear SRAM address (y*320+x) with range check.
module coord_to_address
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH  = memory_arbiter_pkg::SCREEN_WIDTH,
    parameter int unsigned HEIGHT = memory_arbiter_pkg::SCREEN_HEIGHT
) (
    input  logic [8:0]             i_x,
    input  logic [7:0]             i_y,
    output logic [SRAM_ADDR_W-1:0] o_address,
    output logic                   o_in_range
);

    // Shift-add form of y*320, all terms widened to 17 bits so nothing truncates.
    always_comb begin
        o_address = {1'b0, i_y, 8'b0} + {3'b0, i_y, 6'b0} + {8'b0, i_x};
        o_in_range = (32'(i_x) < WIDTH) && (32'(i_y) < HEIGHT);
    end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates scan-out reads and MCU writes onto one asynchronous SRAM with fixed-length strobes.
module memory_arbiter #(
    parameter int unsigned WAIT_CYCLES   = 2,
    parameter int unsigned SCREEN_WIDTH  = memory_arbiter_pkg::SCREEN_WIDTH,
    parameter int unsigned SCREEN_HEIGHT = memory_arbiter_pkg::SCREEN_HEIGHT
) (
    input  logic             clock,
    input  logic             resetN,
    memory_arbiter_if.slave  bus
);
    import memory_arbiter_pkg::*;

    localparam logic [2:0] LastCnt = 3'(WAIT_CYCLES - 1);

    state_e                 r_state;
    state_e                 w_state_d;
    logic [2:0]             r_cnt;
    logic [2:0]             w_cnt_d;
    logic                   r_last_read;
    logic                   r_is_read;
    logic [SRAM_ADDR_W-1:0] r_addr;
    logic [7:0]             r_wdata;
    logic [7:0]             r_rdata;

    logic                   w_grant_read;
    logic                   w_grant_write;
    logic                   w_latch;
    logic [8:0]             w_sel_x;
    logic [7:0]             w_sel_y;
    logic [SRAM_ADDR_W-1:0] w_addr;
    logic                   w_in_range;

    logic                   w_ce_n;
    logic                   w_oe_n;
    logic                   w_we_n;
    logic                   w_doe;
    logic                   w_read_cmp;
    logic                   w_write_cmp;

    // Read wins a tie unless the last grant was a read, bounding write wait to one read.
    always_comb begin
        w_grant_read  = bus.videoReadRequest &&
                        (!bus.memoryWriteRequest || !r_last_read);
        w_grant_write = bus.memoryWriteRequest && !w_grant_read;
        w_sel_x       = w_grant_read ? bus.videoXCoord : bus.memoryXCoord;
        w_sel_y       = w_grant_read ? bus.videoYCoord : bus.memoryYCoord;
    end

    coord_to_address #(
        .WIDTH  (SCREEN_WIDTH),
        .HEIGHT (SCREEN_HEIGHT)
    ) u_coord_to_address (
        .i_x        (w_sel_x),
        .i_y        (w_sel_y),
        .o_address  (w_addr),
        .o_in_range (w_in_range)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_latch     = 1'b0;
        w_ce_n      = 1'b1;
        w_oe_n      = 1'b1;
        w_we_n      = 1'b1;
        w_doe       = 1'b0;
        w_read_cmp  = 1'b0;
        w_write_cmp = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_grant_read || w_grant_write) begin
                    w_latch = 1'b1;
                    w_cnt_d = '0;
                    if (!w_in_range) begin
                        w_state_d = StSkipDone;
                    end else if (w_grant_read) begin
                        w_state_d = StRead;
                    end else begin
                        w_state_d = StWrite;
                    end
                end
            end
            StRead: begin
                w_ce_n = 1'b0;
                w_oe_n = 1'b0;
                if (r_cnt == LastCnt) begin
                    w_state_d = StReadDone;
                end else begin
                    w_cnt_d = r_cnt + 3'd1;
                end
            end
            StWrite: begin
                w_ce_n = 1'b0;
                w_we_n = 1'b0;
                w_doe  = 1'b1;
                if (r_cnt == LastCnt) begin
                    w_state_d = StWriteDone;
                end else begin
                    w_cnt_d = r_cnt + 3'd1;
                end
            end
            StReadDone: begin
                w_read_cmp = 1'b1;
                w_state_d  = StIdle;
            end
            StWriteDone: begin
                // Keep driving data for hold time after the write strobe rises.
                w_doe       = 1'b1;
                w_write_cmp = 1'b1;
                w_state_d   = StIdle;
            end
            StSkipDone: begin
                w_read_cmp  = r_is_read;
                w_write_cmp = !r_is_read;
                w_state_d   = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_last_read <= 1'b0;
            r_is_read   <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
        end else begin
            if (w_latch) begin
                r_last_read <= w_grant_read;
                r_is_read   <= w_grant_read;
                r_addr      <= w_addr;
                if (w_grant_write) begin
                    r_wdata <= bus.memoryWriteData;
                end
                if (w_grant_read && !w_in_range) begin
                    r_rdata <= '0;
                end
            end
            if (r_state == StRead && r_cnt == LastCnt) begin
                r_rdata <= bus.sramDataIn;
            end
        end
    end

    assign bus.videoReadData       = r_rdata;
    assign bus.videoReadComplete   = w_read_cmp;
    assign bus.memoryWriteComplete = w_write_cmp;
    assign bus.sramAddress         = r_addr;
    assign bus.sramDataOut         = r_wdata;
    assign bus.sramDataOutEnable   = w_doe;
    assign bus.sramChipEnableN     = w_ce_n;
    assign bus.sramOutputEnableN   = w_oe_n;
    assign bus.sramWriteEnableN    = w_we_n;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter with hand-computed cycle expectations.
module tb_memory_arbiter;

    logic clock;
    logic resetN;
    int   n_cmp;
    int   n_err;
    int   rd_target;
    bit   scramble;

    logic        a_ce   [1:16];
    logic        a_oe   [1:16];
    logic        a_we   [1:16];
    logic        a_doe  [1:16];
    logic        a_rc   [1:16];
    logic        a_wc   [1:16];
    logic [16:0] a_addr [1:16];
    logic [7:0]  a_dout [1:16];
    logic [7:0]  a_rdata[1:16];

    memory_arbiter_if u_bus ();

    memory_arbiter #(
        .WAIT_CYCLES   (2),
        .SCREEN_WIDTH  (320),
        .SCREEN_HEIGHT (240)
    ) u_dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (u_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Steps n cycles (cycle 1 = first cycle after the grant edge), recording outputs
    // and acting as a requester that drops its request on completion.
    task automatic run(input int n);
        int rd_done = 0;
        for (int c = 1; c <= n; c++) begin
            @(posedge clock);
            #1;
            a_ce[c]    = u_bus.sramChipEnableN;
            a_oe[c]    = u_bus.sramOutputEnableN;
            a_we[c]    = u_bus.sramWriteEnableN;
            a_doe[c]   = u_bus.sramDataOutEnable;
            a_rc[c]    = u_bus.videoReadComplete;
            a_wc[c]    = u_bus.memoryWriteComplete;
            a_addr[c]  = u_bus.sramAddress;
            a_dout[c]  = u_bus.sramDataOut;
            a_rdata[c] = u_bus.videoReadData;
            check_eq($sformatf("oe_we_excl c%0d", c),
                     32'(u_bus.sramOutputEnableN | u_bus.sramWriteEnableN), 32'd1);
            if (scramble && c == 1) begin
                u_bus.videoXCoord     = u_bus.videoXCoord ^ 9'h1;
                u_bus.videoYCoord     = u_bus.videoYCoord ^ 8'h1;
                u_bus.memoryXCoord    = u_bus.memoryXCoord ^ 9'h1;
                u_bus.memoryYCoord    = u_bus.memoryYCoord ^ 8'h1;
                u_bus.memoryWriteData = u_bus.memoryWriteData ^ 8'hFF;
            end
            if (c == 3) u_bus.sramDataIn = 8'hEE;
            if (a_rc[c]) begin
                rd_done++;
                if (rd_done >= rd_target) u_bus.videoReadRequest = 1'b0;
            end
            if (a_wc[c]) u_bus.memoryWriteRequest = 1'b0;
        end
    endtask

    task automatic check_pulses(input string tag, input int n, input logic [15:0] rc_mask,
                                input logic [15:0] wc_mask);
        for (int c = 1; c <= n; c++) begin
            check_eq($sformatf("%s rc c%0d", tag, c), 32'(a_rc[c]), 32'(rc_mask[c]));
            check_eq($sformatf("%s wc c%0d", tag, c), 32'(a_wc[c]), 32'(wc_mask[c]));
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rd_target = 1;
        scramble  = 1'b0;
        resetN    = 1'b0;
        u_bus.videoXCoord        = '0;
        u_bus.videoYCoord        = '0;
        u_bus.videoReadRequest   = 1'b0;
        u_bus.memoryXCoord       = '0;
        u_bus.memoryYCoord       = '0;
        u_bus.memoryWriteRequest = 1'b0;
        u_bus.memoryWriteData    = '0;
        u_bus.sramDataIn         = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst ce_n", 32'(u_bus.sramChipEnableN), 32'd1);
        check_eq("rst oe_n", 32'(u_bus.sramOutputEnableN), 32'd1);
        check_eq("rst we_n", 32'(u_bus.sramWriteEnableN), 32'd1);
        check_eq("rst doe", 32'(u_bus.sramDataOutEnable), 32'd0);
        check_eq("rst addr", 32'(u_bus.sramAddress), 32'd0);
        check_eq("rst dout", 32'(u_bus.sramDataOut), 32'd0);
        check_eq("rst rdata", 32'(u_bus.videoReadData), 32'd0);
        check_eq("rst rc", 32'(u_bus.videoReadComplete), 32'd0);
        check_eq("rst wc", 32'(u_bus.memoryWriteComplete), 32'd0);
        @(negedge clock);
        resetN = 1'b1;
        @(posedge clock);
        #1;
        check_eq("idle ce_n", 32'(u_bus.sramChipEnableN), 32'd1);
        check_eq("idle rc", 32'(u_bus.videoReadComplete), 32'd0);

        // Read x=10,y=2 -> 0x28A; coordinates scrambled mid-access must be ignored
        u_bus.videoXCoord      = 9'd10;
        u_bus.videoYCoord      = 8'd2;
        u_bus.sramDataIn       = 8'h5A;
        u_bus.videoReadRequest = 1'b1;
        scramble = 1'b1;
        run(5);
        check_eq("rd addr c1", 32'(a_addr[1]), 32'h28A);
        check_eq("rd addr c2", 32'(a_addr[2]), 32'h28A);
        check_eq("rd oe_n c1", 32'(a_oe[1]), 32'd0);
        check_eq("rd oe_n c2", 32'(a_oe[2]), 32'd0);
        check_eq("rd ce_n c1", 32'(a_ce[1]), 32'd0);
        check_eq("rd we_n c1", 32'(a_we[1]), 32'd1);
        check_eq("rd oe_n c3", 32'(a_oe[3]), 32'd1);
        check_eq("rd data c3", 32'(a_rdata[3]), 32'h5A);
        check_eq("rd data c5", 32'(a_rdata[5]), 32'h5A);
        check_pulses("rd", 5, 16'h0008, 16'h0000);

        // Write x=319,y=239 -> 0x12BFF, data 0xC3
        u_bus.memoryXCoord       = 9'd319;
        u_bus.memoryYCoord       = 8'd239;
        u_bus.memoryWriteData    = 8'hC3;
        u_bus.memoryWriteRequest = 1'b1;
        run(5);
        check_eq("wr addr c1", 32'(a_addr[1]), 32'h12BFF);
        check_eq("wr addr c3", 32'(a_addr[3]), 32'h12BFF);
        check_eq("wr we_n c1", 32'(a_we[1]), 32'd0);
        check_eq("wr we_n c2", 32'(a_we[2]), 32'd0);
        check_eq("wr we_n c3", 32'(a_we[3]), 32'd1);
        check_eq("wr oe_n c1", 32'(a_oe[1]), 32'd1);
        for (int c = 1; c <= 3; c++) begin
            check_eq($sformatf("wr doe c%0d", c), 32'(a_doe[c]), 32'd1);
            check_eq($sformatf("wr dout c%0d", c), 32'(a_dout[c]), 32'hC3);
        end
        check_eq("wr doe c4", 32'(a_doe[4]), 32'd0);
        check_pulses("wr", 5, 16'h0000, 16'h0008);

        // Simultaneous read+write, reader re-requests: read, write, read
        scramble  = 1'b0;
        rd_target = 2;
        u_bus.sramDataIn         = 8'h44;
        u_bus.videoXCoord        = 9'd1;
        u_bus.videoYCoord        = 8'd0;
        u_bus.memoryXCoord       = 9'd2;
        u_bus.memoryYCoord       = 8'd0;
        u_bus.memoryWriteData    = 8'h77;
        u_bus.videoReadRequest   = 1'b1;
        u_bus.memoryWriteRequest = 1'b1;
        run(12);
        rd_target = 1;
        check_pulses("arb", 12, 16'h0808, 16'h0080);
        check_eq("arb addr c1", 32'(a_addr[1]), 32'h1);
        check_eq("arb addr c5", 32'(a_addr[5]), 32'h2);
        check_eq("arb we_n c5", 32'(a_we[5]), 32'd0);
        check_eq("arb dout c5", 32'(a_dout[5]), 32'h77);
        check_eq("arb oe_n c9", 32'(a_oe[9]), 32'd0);
        check_eq("arb data c3", 32'(a_rdata[3]), 32'h44);
        check_eq("arb data c11", 32'(a_rdata[11]), 32'hEE);

        // Out-of-range write x=320: no strobe, complete in cycle 1
        u_bus.memoryXCoord       = 9'd320;
        u_bus.memoryYCoord       = 8'd0;
        u_bus.memoryWriteRequest = 1'b1;
        run(2);
        check_pulses("skipwr", 2, 16'h0000, 16'h0002);
        check_eq("skipwr we_n c1", 32'(a_we[1]), 32'd1);
        check_eq("skipwr ce_n c1", 32'(a_ce[1]), 32'd1);
        check_eq("skipwr doe c1", 32'(a_doe[1]), 32'd0);

        // Out-of-range read y=240: returns 0x00 in cycle 1
        u_bus.videoXCoord      = 9'd0;
        u_bus.videoYCoord      = 8'd240;
        u_bus.videoReadRequest = 1'b1;
        run(2);
        check_pulses("skiprd", 2, 16'h0002, 16'h0000);
        check_eq("skiprd data c1", 32'(a_rdata[1]), 32'h0);
        check_eq("skiprd oe_n c1", 32'(a_oe[1]), 32'd1);
        check_eq("skiprd ce_n c1", 32'(a_ce[1]), 32'd1);

        // Reset during write cycle 1 aborts; held request is served after release
        u_bus.memoryXCoord       = 9'd5;
        u_bus.memoryYCoord       = 8'd1;
        u_bus.memoryWriteData    = 8'h3C;
        u_bus.memoryWriteRequest = 1'b1;
        @(posedge clock);
        #1;
        check_eq("abort we_n pre", 32'(u_bus.sramWriteEnableN), 32'd0);
        #1;
        resetN = 1'b0;
        #1;
        check_eq("abort we_n", 32'(u_bus.sramWriteEnableN), 32'd1);
        check_eq("abort ce_n", 32'(u_bus.sramChipEnableN), 32'd1);
        check_eq("abort doe", 32'(u_bus.sramDataOutEnable), 32'd0);
        check_eq("abort addr", 32'(u_bus.sramAddress), 32'd0);
        for (int c = 1; c <= 2; c++) begin
            @(posedge clock);
            #1;
            check_eq($sformatf("abort wc c%0d", c), 32'(u_bus.memoryWriteComplete), 32'd0);
            check_eq($sformatf("abort we_n c%0d", c), 32'(u_bus.sramWriteEnableN), 32'd1);
        end
        @(negedge clock);
        resetN = 1'b1;
        run(4);
        check_pulses("resume", 4, 16'h0000, 16'h0008);
        check_eq("resume we_n c1", 32'(a_we[1]), 32'd0);
        check_eq("resume addr c1", 32'(a_addr[1]), 32'h145);
        check_eq("resume dout c1", 32'(a_dout[1]), 32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
